// File: rtl/dist_pkg.sv
// Shared widths, SRAM map constant and one-hot state encoding for the coefficient SRAM arbiter.
package dist_pkg;

   localparam int unsigned COE_ADDR_W = 18;
   localparam int unsigned COE_DATA_W = 16;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned ST_W       = 5;

   localparam logic [COE_ADDR_W-1:0] SRAM_COE_BASE = 18'h10000;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE     = 5'b00001,
      ST_RD_WAIT  = 5'b00010,
      ST_WR_SETUP = 5'b00100,
      ST_WR_PULSE = 5'b01000,
      ST_WR_HOLD  = 5'b10000
   } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the reader not served last wins.
module rr_pick2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_gnt_idx_c,
   output logic o_gnt_vld_c
);

   always_comb begin
      o_gnt_vld_c = i_req0 | i_req1;
      o_gnt_idx_c = (i_req0 & i_req1) ? ~i_last : i_req1;
   end

endmodule

// File: rtl/coe_sram_arbiter.sv
// Coefficient SRAM arbiter: fixed-priority writer, two round-robin readers,
// serialised single-port SRAM accesses with registered strobes.
module coe_sram_arbiter
   import dist_pkg::*;
#(
   parameter int unsigned ADDR_W = COE_ADDR_W,
   parameter int unsigned DATA_W = COE_DATA_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              i_clk_50m,
   input  logic              i_rst,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd0_req,
   input  logic [ADDR_W-1:0] i_rd0_addr,
   output logic              o_rd0_valid,
   output logic [DATA_W-1:0] o_rd0_data,
   input  logic              i_rd1_req,
   input  logic [ADDR_W-1:0] i_rd1_addr,
   output logic              o_rd1_valid,
   output logic [DATA_W-1:0] o_rd1_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_wdata,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   input  logic [DATA_W-1:0] i_sram_rdata
);

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_q, last_d;
   logic                sel_q, sel_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                oe_n_q, oe_n_d;
   logic                we_n_q, we_n_d;
   logic                wr_ack_q, wr_ack_d;
   logic                rd0_valid_q, rd0_valid_d;
   logic                rd1_valid_q, rd1_valid_d;
   logic [DATA_W-1:0]   rd0_data_q, rd0_data_d;
   logic [DATA_W-1:0]   rd1_data_q, rd1_data_d;

   logic wr_msk, rd0_msk, rd1_msk;
   logic gnt_idx_c, gnt_vld_c;

   // A requester whose completion pulse is up this cycle may still show its old level.
   assign wr_msk  = i_wr_req  & ~wr_ack_q;
   assign rd0_msk = i_rd0_req & ~rd0_valid_q;
   assign rd1_msk = i_rd1_req & ~rd1_valid_q;

   rr_pick2 u_rr (
      .i_req0      (rd0_msk),
      .i_req1      (rd1_msk),
      .i_last      (last_q),
      .o_gnt_idx_c (gnt_idx_c),
      .o_gnt_vld_c (gnt_vld_c)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      oe_n_d      = oe_n_q;
      we_n_d      = we_n_q;
      wr_ack_d    = 1'b0;
      rd0_valid_d = 1'b0;
      rd1_valid_d = 1'b0;
      rd0_data_d  = rd0_data_q;
      rd1_data_d  = rd1_data_q;

      case (state_q)
         ST_IDLE: begin
            oe_n_d = 1'b1;
            we_n_d = 1'b1;
            if (wr_msk) begin
               addr_d  = i_wr_addr;
               wdata_d = i_wr_data;
               state_d = ST_WR_SETUP;
            end else if (gnt_vld_c) begin
               addr_d  = gnt_idx_c ? i_rd1_addr : i_rd0_addr;
               oe_n_d  = 1'b0;
               cnt_d   = '0;
               sel_d   = gnt_idx_c;
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == RD_LAST) begin
               if (sel_q) begin
                  rd1_data_d  = i_sram_rdata;
                  rd1_valid_d = 1'b1;
               end else begin
                  rd0_data_d  = i_sram_rdata;
                  rd0_valid_d = 1'b1;
               end
               oe_n_d  = 1'b1;
               last_d  = sel_q;
               state_d = ST_IDLE;
            end
         end
         ST_WR_SETUP: begin
            we_n_d  = 1'b0;
            state_d = ST_WR_PULSE;
         end
         ST_WR_PULSE: begin
            we_n_d  = 1'b1;
            state_d = ST_WR_HOLD;
         end
         ST_WR_HOLD: begin
            wr_ack_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Last-served resets to reader 1 so reader 0 wins the first tie.
   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         wr_ack_q    <= 1'b0;
         rd0_valid_q <= 1'b0;
         rd1_valid_q <= 1'b0;
         rd0_data_q  <= '0;
         rd1_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         wr_ack_q    <= wr_ack_d;
         rd0_valid_q <= rd0_valid_d;
         rd1_valid_q <= rd1_valid_d;
         rd0_data_q  <= rd0_data_d;
         rd1_data_q  <= rd1_data_d;
      end
   end

   assign o_wr_ack     = wr_ack_q;
   assign o_rd0_valid  = rd0_valid_q;
   assign o_rd0_data   = rd0_data_q;
   assign o_rd1_valid  = rd1_valid_q;
   assign o_rd1_data   = rd1_data_q;
   assign o_sram_addr  = addr_q;
   assign o_sram_wdata = wdata_q;
   assign o_sram_oe_n  = oe_n_q;
   assign o_sram_we_n  = we_n_q;

endmodule

// File: tb/tb_coe_sram_arbiter.sv
// Scoreboard bench for coe_sram_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
module tb_coe_sram_arbiter;
   import dist_pkg::*;

   localparam int unsigned AW = COE_ADDR_W;
   localparam int unsigned DW = COE_DATA_W;
   localparam int NI = 2;

   localparam logic [AW-1:0] A_05  = SRAM_COE_BASE + 18'h00005;
   localparam logic [AW-1:0] A_10  = SRAM_COE_BASE + 18'h00010;
   localparam logic [AW-1:0] A_11  = SRAM_COE_BASE + 18'h00011;
   localparam logic [AW-1:0] A_12  = SRAM_COE_BASE + 18'h00012;
   localparam logic [AW-1:0] A_200 = SRAM_COE_BASE + 18'h00200;
   localparam logic [AW-1:0] A_300 = SRAM_COE_BASE + 18'h00300;
   localparam logic [AW-1:0] A_400 = SRAM_COE_BASE + 18'h00400;

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   int   we_len [NI];
   exp_t q [NI*3][$];
   string sname [3] = '{"rd0", "rd1", "wr"};

   logic          wr_req   [NI];
   logic [AW-1:0] wr_addr  [NI];
   logic [DW-1:0] wr_data  [NI];
   logic          wr_ack   [NI];
   logic          rd_req   [NI][2];
   logic [AW-1:0] rd_addr  [NI][2];
   logic          rd_valid [NI][2];
   logic [DW-1:0] rd_data  [NI][2];
   logic [AW-1:0] s_addr   [NI];
   logic [DW-1:0] s_wdata  [NI];
   logic          oe_n     [NI];
   logic          we_n     [NI];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
      case (a)
         A_05:    return 16'h0A3C;
         A_10:    return 16'h1111;
         A_11:    return 16'h2222;
         A_12:    return 16'h3333;
         default: return 16'h0000;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_i
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [DW-1:0] mem [logic [AW-1:0]];
      logic [DW-1:0] rdata;
      int            oe_cnt;

      // Async SRAM model: data is only valid once oe_n has been low long enough.
      always @(posedge clk) begin
         if (!we_n[g]) mem[s_addr[g]] = s_wdata[g];
         oe_cnt <= oe_n[g] ? 0 : oe_cnt + 1;
      end

      always_comb begin
         if (!oe_n[g] && oe_cnt >= LAT - 1)
            rdata = mem.exists(s_addr[g]) ? mem[s_addr[g]] : rom(s_addr[g]);
         else
            rdata = 16'hDEAD;
      end

      coe_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
         .i_clk_50m    (clk),
         .i_rst        (rst),
         .i_wr_req     (wr_req[g]),
         .i_wr_addr    (wr_addr[g]),
         .i_wr_data    (wr_data[g]),
         .o_wr_ack     (wr_ack[g]),
         .i_rd0_req    (rd_req[g][0]),
         .i_rd0_addr   (rd_addr[g][0]),
         .o_rd0_valid  (rd_valid[g][0]),
         .o_rd0_data   (rd_data[g][0]),
         .i_rd1_req    (rd_req[g][1]),
         .i_rd1_addr   (rd_addr[g][1]),
         .o_rd1_valid  (rd_valid[g][1]),
         .o_rd1_data   (rd_data[g][1]),
         .o_sram_addr  (s_addr[g]),
         .o_sram_wdata (s_wdata[g]),
         .o_sram_oe_n  (oe_n[g]),
         .o_sram_we_n  (we_n[g]),
         .i_sram_rdata (rdata)
      );
   end

   task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got 'h%0h, required 'h%0h (cycle %0d)", name, g, act, exp, cyc);
      end
   endtask

   // Monitor: pops the expected pulse for every valid/ack and checks cycle and data.
   always @(negedge clk) begin
      exp_t          e;
      logic          ev;
      logic [DW-1:0] dat;
      for (int g = 0; g < NI; g++) begin
         check("strobe_overlap", g, 32'(!oe_n[g] && !we_n[g]), 32'd0);
         if (!we_n[g]) we_len[g]++;
         else if (we_len[g] != 0) begin
            check("we_pulse_len", g, 32'(we_len[g]), 32'd1);
            we_len[g] = 0;
         end
         for (int s = 0; s < 3; s++) begin
            if (s == 2) begin
               ev  = wr_ack[g];
               dat = '0;
            end else begin
               ev  = rd_valid[g][s[0]];
               dat = rd_data[g][s[0]];
            end
            if (ev) begin
               if (q[g*3+s].size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_%s inst%0d: pulse at cycle %0d, required none", sname[s], g, cyc);
               end else begin
                  e = q[g*3+s].pop_front();
                  check({sname[s], "_cycle"}, g, 32'(cyc), 32'(e.cyc));
                  if (s != 2) check({sname[s], "_data"}, g, 32'(dat), 32'(e.data));
               end
            end
         end
      end
   end

   task automatic do_read(input int g, input int r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int lat);
      exp_t e;
      bit   seen;
      rd_addr[g][r] = a;
      rd_req[g][r]  = 1'b1;
      e.cyc  = cyc + lat;
      e.data = d;
      q[g*3+r].push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = rd_valid[g][r];
      end
      check("rd_seen", g, 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      rd_req[g][r] = 1'b0;
   endtask

   task automatic do_write(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
      exp_t e;
      bit   seen;
      wr_addr[g] = a;
      wr_data[g] = d;
      wr_req[g]  = 1'b1;
      e.cyc  = cyc + lat;
      e.data = '0;
      q[g*3+2].push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = wr_ack[g];
      end
      check("wr_seen", g, 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      wr_req[g] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         wr_req[g]  = 1'b0;
         wr_addr[g] = '0;
         wr_data[g] = '0;
         for (int r = 0; r < 2; r++) begin
            rd_req[g][r]  = 1'b0;
            rd_addr[g][r] = '0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         check("rst_addr", g, 32'(s_addr[g]), 32'd0);
         check("rst_wdata", g, 32'(s_wdata[g]), 32'd0);
         check("rst_oe_n", g, 32'(oe_n[g]), 32'd1);
         check("rst_we_n", g, 32'(we_n[g]), 32'd1);
         check("rst_wr_ack", g, 32'(wr_ack[g]), 32'd0);
         check("rst_rd0_valid", g, 32'(rd_valid[g][0]), 32'd0);
         check("rst_rd1_valid", g, 32'(rd_valid[g][1]), 32'd0);
         check("rst_rd0_data", g, 32'(rd_data[g][0]), 32'd0);
         check("rst_rd1_data", g, 32'(rd_data[g][1]), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single reader 0 request, held through its valid cycle.
      fork
         do_read(0, 0, A_05, 16'h0A3C, 2);
         begin
            @(posedge clk);
            #1;
            check("grant_addr", 0, 32'(s_addr[0]), 32'(A_05));
            check("grant_oe_n", 0, 32'(oe_n[0]), 32'd0);
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("rd0_data_hold", 0, 32'(rd_data[0][0]), 32'h0A3C);

      // Write and reader 1 together: write first, then reader 1 reads it back.
      fork
         do_write(0, A_200, 16'hF012, 4);
         do_read(0, 1, A_200, 16'hF012, 6);
      join
      repeat (3) @(posedge clk);
      #1;

      // Both readers held: rd0, rd1, then rd0's reissued request.
      fork
         begin
            do_read(0, 0, A_10, 16'h1111, 2);
            do_read(0, 0, A_12, 16'h3333, 3);
         end
         do_read(0, 1, A_11, 16'h2222, 4);
      join
      repeat (3) @(posedge clk);
      #1;

      // RD_LAT=3: write and reader 1 arrive mid-read; write wins the next IDLE.
      fork
         do_read(1, 0, A_05, 16'h0A3C, 4);
         begin
            @(posedge clk);
            #1;
            fork
               do_write(1, A_300, 16'h5A5A, 7);
               do_read(1, 1, A_300, 16'h5A5A, 11);
            join
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of the write strobe.
      wr_addr[0] = A_400;
      wr_data[0] = 16'h7777;
      wr_req[0]  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #5;
      check("we_low_in_pulse", 0, 32'(we_n[0]), 32'd0);
      rst = 1'b1;
      #1;
      check("we_n_async_rst", 0, 32'(we_n[0]), 32'd1);
      check("oe_n_async_rst", 0, 32'(oe_n[0]), 32'd1);
      wr_req[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_write(0, A_400, 16'h7777, 4);
      fork
         do_read(0, 0, A_400, 16'h7777, 2);
         do_read(0, 1, A_05, 16'h0A3C, 4);
      join
      repeat (6) @(posedge clk);
      #1;

      for (int i = 0; i < NI*3; i++)
         check({"drained_", sname[i%3]}, i/3, 32'(q[i].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
